reg_share_arbiter: RTL and testbench
====================================

# reg_share_arbiter

Round-robin arbiter that shares one WIDTH-bit D-flip-flop register between N_REQ requesters. Each requester asks for write access. The arbiter grants exactly one requester at a time, loads that requester's data into the shared register, and signals completion. The block sits between the requesting datapath stages and the shared storage register, which is built from D flip-flops with asynchronous reset.

## Interface
- N_REQ, 4, number of requesters (legal range 2..8)
- WIDTH, 8, width of the shared register and of each write-data lane
- IDW, $clog2(N_REQ), width of requester index (derived, not overridable)

- clk  in  1  clock, rising-edge active
- rst  in  1  reset, asynchronous, active-high
- req  in  N_REQ  per-requester write request, level
- wdata  in  N_REQ*WIDTH  flattened write data; lane i = wdata[i*WIDTH +: WIDTH]
- gnt  out  N_REQ  one-hot grant, registered
- done  out  1  one-cycle pulse: shared register has just been updated
- busy  out  1  high while a transaction is in progress (GRANT or DONE)
- owner  out  IDW  index of the last requester whose data was written
- q  out  WIDTH  shared register contents

## Operation
- FSM states: IDLE, GRANT, DONE.
- IDLE:
  - If req is nonzero, select a winner by round-robin and go to GRANT.
  - Otherwise stay in IDLE.
- Round-robin rule:
  - Search starts at index ptr and ascends modulo N_REQ.
  - The first set req bit wins.
  - ptr resets to 0.
  - ptr becomes winner+1 (mod N_REQ) on entry to DONE.
- GRANT (one cycle):
  - gnt is one-hot at the winner; busy = 1.
  - The shared register enable is high, and the register captures lane[winner] at the closing clock edge.
  - Go to DONE unconditionally.
- DONE (one cycle):
  - gnt = 0, done = 1, busy = 1.
  - q holds the new value; owner = winner.
  - Go to IDLE.
- The winner is latched on IDLE→GRANT. req and wdata changes of other requesters during GRANT do not affect the transaction.
- If the winner deasserts req during GRANT, the write still commits. A grant is never revoked.
- If a requester deasserts req before the IDLE sampling edge, it is not considered.
- Multiple simultaneous requests are served one per transaction in round-robin order. No requester waits more than N_REQ transactions.
- q changes only on the GRANT→DONE edge or on reset.
- Reset values: state = IDLE, gnt = 0, done = 0, busy = 0, owner = 0, q = 0, ptr = 0.
- Reset asserted mid-transaction:
  - Everything clears immediately, without waiting for clk.
  - Any pending write is discarded and done is not pulsed.
  - After rst is released, arbitration restarts with ptr = 0.

## Timing
- Request sampled in IDLE at edge t → gnt high during cycle t+1 → q updated and done high during cycle t+2 → IDLE during cycle t+3.
- Transaction length is 3 cycles. Back-to-back throughput is one write per 3 cycles.
- All outputs are registered; there is no combinational path from req or wdata to any output.
- gnt and done are never high in the same cycle. done is never high for two consecutive cycles.

## Structure
- Shared package `reg_share_pkg`:
  - State enum typedef (IDLE, GRANT, DONE).
  - Default N_REQ and WIDTH constants.
- Sub-module `reg_d_bank`:
  - WIDTH-bit D register with asynchronous active-high reset to 0 and a synchronous load enable.
  - Instantiated once for q.
- The arbiter keeps the FSM, the ptr/winner registers and the round-robin selector. The selector is a combinational priority search rotated by ptr.

## Test plan
- Reset: assert rst mid-cycle with no clk edge → gnt=0, done=0, busy=0, owner=0, q=0 immediately.
- Single request:
  - Stimulus: req=0100, lane2=0xA5, sampled at edge t.
  - Required: gnt=0100 in cycle t+1; q=0xA5, owner=2, done=1 in cycle t+2; idle in t+3.
- Fairness:
  - Stimulus: req=1111 held continuously from reset; lanes 0x10, 0x21, 0x32, 0x43.
  - Required: grants 0,1,2,3,0 in that order, 3 cycles apart; q follows 0x10, 0x21, 0x32, 0x43, 0x10.
- Rotation:
  - Stimulus: grant 2 completes, then req=0101 is presented.
  - Required: requester 0 wins (search starts at 3, wraps to 0); the next transaction grants 2.
- Request drop:
  - Stimulus: the winner deasserts req during GRANT.
  - Required: done still pulses and q gets its lane value.
- Reset mid-GRANT:
  - Stimulus: q=0x55, rst pulsed while gnt=0010 with lane1=0xFF.
  - Required: q=0, no done pulse; with req=0011 after release, requester 0 is granted first.

Source files
------------

// File: rtl/reg_share_pkg.sv
// Shared types and defaults for the round-robin shared-register arbiter.
package reg_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/reg_share_arbiter_if.sv
// Requester-side bus of the shared-register arbiter.
// Handshake: req is a level held by a requester; gnt (registered, one-hot) grants
// exactly one requester for one cycle, done pulses once the shared register holds its lane.
interface reg_share_arbiter_if
    import reg_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) ();
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic                   done;
    logic                   busy;
    logic [IDW-1:0]         owner;
    logic [WIDTH-1:0]       q;

    modport master (
        output req, wdata,
        input  gnt, done, busy, owner, q
    );

    modport slave (
        input  req, wdata,
        output gnt, done, busy, owner, q
    );
endinterface

// File: rtl/reg_d_bank.sv
// WIDTH-bit D register, asynchronous active-high clear, synchronous load enable.
module reg_d_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end
endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a shared register.
module reg_share_arbiter
    import reg_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    reg_share_arbiter_if.slave bus,
    output state_t             fsm_state
);
    localparam int IDW = $clog2(N_REQ);
    localparam logic [IDW-1:0] LAST = IDW'(N_REQ - 1);

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   sel;
    logic             found;
    logic [WIDTH-1:0] lane;
    logic [N_REQ-1:0] gnt_r;
    logic             done_r;
    logic             busy_r;
    logic [IDW-1:0]   owner_r;

    // Priority search starting at ptr and wrapping modulo N_REQ.
    always_comb begin : rr_search
        int idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
    end

    always_comb begin
        lane = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == IDW'(i)) begin
                lane = bus.wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            winner  <= '0;
            gnt_r   <= '0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            owner_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (found) begin
                        winner <= sel;
                        gnt_r  <= N_REQ'(1) << sel;
                        busy_r <= 1'b1;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    // The write commits regardless of what req does now.
                    gnt_r   <= '0;
                    done_r  <= 1'b1;
                    owner_r <= winner;
                    ptr     <= (winner == LAST) ? '0 : winner + 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    gnt_r  <= '0;
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    reg_d_bank #(.WIDTH(WIDTH)) u_bank (
        .clk  (clk),
        .rst  (rst),
        .load (state == GRANT),
        .d    (lane),
        .q    (bus.q)
    );

    assign bus.gnt   = gnt_r;
    assign bus.done  = done_r;
    assign bus.busy  = busy_r;
    assign bus.owner = owner_r;
    assign fsm_state = state;
endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter: per-cycle vector table plus multi-cycle corner sequences.
module tb_reg_share_arbiter;
    import reg_share_pkg::*;

    logic   clk;
    logic   rst;
    state_t fsm_state;
    int     checks;
    int     errors;

    reg_share_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

    reg_share_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic        done;
        logic        busy;
        logic [1:0]  owner;
        logic [7:0]  q;
    } vec_t;

    vec_t vecs[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] gnt, input logic done,
                             input logic busy, input logic [1:0] owner, input logic [7:0] q);
        check({tag, " gnt"},   32'(bus.gnt),   32'(gnt));
        check({tag, " done"},  32'(bus.done),  32'(done));
        check({tag, " busy"},  32'(bus.busy),  32'(busy));
        check({tag, " owner"}, 32'(bus.owner), 32'(owner));
        check({tag, " q"},     32'(bus.q),     32'(q));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] lanes;
        checks = 0;
        errors = 0;

        // Single request, rotation past 3 to 0, then 2, request drop, other-lane churn.
        vecs[0]  = '{4'h0, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00};
        vecs[1]  = '{4'h4, 32'h00A5_0000, 4'h4, 1'b0, 1'b1, 2'd0, 8'h00};
        vecs[2]  = '{4'h4, 32'h00A5_0000, 4'h0, 1'b1, 1'b1, 2'd2, 8'hA5};
        vecs[3]  = '{4'h0, 32'h00A5_0000, 4'h0, 1'b0, 1'b0, 2'd2, 8'hA5};
        vecs[4]  = '{4'h5, 32'h0022_0011, 4'h1, 1'b0, 1'b1, 2'd2, 8'hA5};
        vecs[5]  = '{4'h5, 32'h0022_0011, 4'h0, 1'b1, 1'b1, 2'd0, 8'h11};
        vecs[6]  = '{4'h5, 32'h0022_0011, 4'h0, 1'b0, 1'b0, 2'd0, 8'h11};
        vecs[7]  = '{4'h5, 32'h0022_0011, 4'h4, 1'b0, 1'b1, 2'd0, 8'h11};
        vecs[8]  = '{4'h0, 32'h0022_0099, 4'h0, 1'b1, 1'b1, 2'd2, 8'h22};
        vecs[9]  = '{4'h0, 32'h0022_0099, 4'h0, 1'b0, 1'b0, 2'd2, 8'h22};
        vecs[10] = '{4'h8, 32'h7722_0099, 4'h8, 1'b0, 1'b1, 2'd2, 8'h22};
        vecs[11] = '{4'h9, 32'h7722_0099, 4'h0, 1'b1, 1'b1, 2'd3, 8'h77};
        vecs[12] = '{4'h9, 32'h7722_0099, 4'h0, 1'b0, 1'b0, 2'd3, 8'h77};
        vecs[13] = '{4'h9, 32'h7722_0099, 4'h1, 1'b0, 1'b1, 2'd3, 8'h77};
        vecs[14] = '{4'h0, 32'h7722_0099, 4'h0, 1'b1, 1'b1, 2'd0, 8'h99};
        vecs[15] = '{4'h0, 32'h7722_0099, 4'h0, 1'b0, 1'b0, 2'd0, 8'h99};

        // Asynchronous reset seen before any clock edge.
        rst       = 1'b0;
        bus.req   = '0;
        bus.wdata = '0;
        #2;
        rst = 1'b1;
        #1;
        check_all("reset_async", 4'h0, 1'b0, 1'b0, 2'd0, 8'h00);
        check("reset_state", 32'(fsm_state), 32'(IDLE));
        do_reset();

        for (int i = 0; i < 16; i++) begin
            bus.req   = vecs[i].req;
            bus.wdata = vecs[i].wdata;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].done,
                      vecs[i].busy, vecs[i].owner, vecs[i].q);
        end

        // Fairness: all four requesting from reset onward.
        lanes     = 32'h4332_2110;
        bus.req   = 4'hF;
        bus.wdata = lanes;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            int exp_idx;
            exp_idx = k % 4;
            step();
            check($sformatf("fair%0d gnt", k), 32'(bus.gnt), 32'(4'h1 << exp_idx));
            check($sformatf("fair%0d gnt_done_excl", k), 32'(bus.done), 32'd0);
            step();
            check($sformatf("fair%0d done", k), 32'(bus.done), 32'd1);
            check($sformatf("fair%0d q", k), 32'(bus.q), 32'(lanes[exp_idx*8 +: 8]));
            check($sformatf("fair%0d owner", k), 32'(bus.owner), 32'(exp_idx));
            step();
            check($sformatf("fair%0d done_single", k), 32'(bus.done), 32'd0);
            check($sformatf("fair%0d busy_low", k), 32'(bus.busy), 32'd0);
        end

        // Reset during GRANT discards the pending write and restarts at ptr 0.
        bus.req = '0;
        do_reset();
        bus.req   = 4'h1;
        bus.wdata = 32'h0000_FF55;
        step();
        step();
        bus.req = 4'h0;
        check("rmid q_pre", 32'(bus.q), 32'h55);
        step();
        bus.req = 4'h2;
        step();
        check("rmid gnt1", 32'(bus.gnt), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        check_all("rmid async", 4'h0, 1'b0, 1'b0, 2'd0, 8'h00);
        step();
        check("rmid no_done", 32'(bus.done), 32'd0);
        check("rmid q_held", 32'(bus.q), 32'h00);
        bus.req = 4'h3;
        rst     = 1'b0;
        step();
        check("rmid first_gnt", 32'(bus.gnt), 32'h1);
        step();
        check("rmid first_q", 32'(bus.q), 32'h55);
        step();
        step();
        check("rmid second_gnt", 32'(bus.gnt), 32'h2);
        step();
        check("rmid second_q", 32'(bus.q), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
